// File: rtl/processor_defines.sv
// Shared processor encodings: store_control codes, fault causes and the
// store-unit FSM state encoding, wrapped in a package for import.
`ifndef PROCESSOR_DEFINES_SV
`define PROCESSOR_DEFINES_SV

`define STR_NOP 3'b000
`define SB      3'b001
`define SH      3'b010
`define SW      3'b011

package store_unit_pkg;

    // store_control codes as typed constants so importers do not depend on
    // macro visibility across compilation units
    localparam logic [2:0] OP_NOP = `STR_NOP;
    localparam logic [2:0] OP_SB  = `SB;
    localparam logic [2:0] OP_SH  = `SH;
    localparam logic [2:0] OP_SW  = `SW;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_TIMEOUT  = 2'd2
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    // True only for codes that perform a memory write; everything else
    // (including undefined codes) retires like a NOP.
    function automatic logic is_store_op(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

`endif

// File: rtl/store_align.sv
// Store data aligner: replicates the operand across byte lanes, builds the
// byte strobes from the low address bits and flags misaligned accesses.
// Purely combinational so the load-side aligner can share it.
module store_align
    import store_unit_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o
);

    logic [3:0] base_strb;

    // Unshifted strobe pattern and alignment check per access size
    always_comb begin
        base_strb    = 4'b0000;
        misaligned_o = 1'b0;
        case (op_i)
            OP_SB: base_strb = 4'b0001;
            OP_SH: begin
                base_strb    = 4'b0011;
                misaligned_o = lane_i[0];
            end
            OP_SW: begin
                base_strb    = 4'b1111;
                misaligned_o = |lane_i;
            end
            default: base_strb = 4'b0000;
        endcase
    end

    assign wstrb_o = base_strb << lane_i;

    // Each byte lane picks the operand byte that lands on it
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HALF_LO = (gi % 2) * 8;
            assign wdata_o[gi*8 +: 8] = (op_i == OP_SB) ? rs2_i[7:0] :
                                        (op_i == OP_SH) ? rs2_i[HALF_LO +: 8] :
                                                          rs2_i[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_unit.sv
// Store unit: forms the effective address, aligns data, performs one bus
// write with req/gnt/ack and reports done or fault (misalign / timeout).
module store_unit
    import store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [2:0]      store_control,
    input  logic [11:0]     imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_ack,
    output logic            st_done,
    output logic            st_fault,
    output logic [1:0]      fault_cause,
    output logic [XLEN-1:0] fault_addr
);

    // Last counter value at which the transaction may still complete
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   ea_q, ea_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;
    logic [XLEN-1:0]   faddr_q, faddr_d;
    logic              ready_q, ready_d;

    logic [XLEN-1:0]   ea_c;
    logic [XLEN-1:0]   wdata_c;
    logic [3:0]        wstrb_c;
    logic              misaligned_c;

    // Effective address wraps modulo 2^XLEN by construction
    assign ea_c = rs1_data + {{(XLEN-12){imm[11]}}, imm};

    store_align u_align (
        .lane_i       (ea_c[1:0]),
        .op_i         (store_control),
        .rs2_i        (rs2_data),
        .wdata_o      (wdata_c),
        .wstrb_o      (wstrb_c),
        .misaligned_o (misaligned_c)
    );

    // Next-state and registered-output logic; completion is tested before
    // the timeout so a late gnt/ack still wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ea_d    = ea_q;
        req_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        cause_d = cause_q;
        faddr_d = faddr_q;
        case (state_q)
            ST_IDLE: begin
                if (st_valid) begin
                    cnt_d = 8'd0;
                    ea_d  = ea_c;
                    if (!is_store_op(store_control)) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                    end else if (misaligned_c) begin
                        state_d = ST_RESP;
                        fault_d = 1'b1;
                        cause_d = FLT_MISALIGN;
                        faddr_d = ea_c;
                    end else begin
                        state_d = ST_ISSUE;
                        req_d   = 1'b1;
                        addr_d  = {ea_c[XLEN-1:2], 2'b00};
                        wdata_d = wdata_c;
                        wstrb_d = wstrb_c;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_gnt && mem_ack) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                end else if (mem_gnt) begin
                    state_d = ST_WAIT_ACK;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = ST_RESP;
                    fault_d = 1'b1;
                    cause_d = FLT_TIMEOUT;
                    faddr_d = ea_q;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = ST_RESP;
                    fault_d = 1'b1;
                    cause_d = FLT_TIMEOUT;
                    faddr_d = ea_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready_d = (state_d == ST_IDLE);

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            ea_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= FLT_NONE;
            faddr_q <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ea_q    <= ea_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            faddr_q <= faddr_d;
            ready_q <= ready_d;
        end
    end

    assign st_ready    = ready_q;
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign st_done     = done_q;
    assign st_fault    = fault_q;
    assign fault_cause = cause_q;
    assign fault_addr  = faddr_q;

endmodule
